// File: rtl/spi_slave_sync_pkg.sv
// spi_slave_pkg: shared types and constants for the SPI slave front end.
//   state_t   : frame FSM states
//   CMDBITS   : bits in the command byte
//   FRAMEBITS : bits per frame
//   WRBIT     : write flag position inside the command byte
package spi_slave_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  localparam int CMDBITS   = 8;
  localparam int FRAMEBITS = 16;
  localparam int WRBIT     = 7;
endpackage

// File: rtl/spi_slave_sync_if.sv
// spi_slave_sync_if: SPI pins plus the register-file side of the slave.
//   sclk/ss/mosi : SPI pins (driven by master)
//   rddata       : read data from the decoder, function of addr
//   miso/spioe   : serial read data and its output enable
//   addr/wrtdata : decoded address and write data
//   we/rdt       : one-clock write / read-transaction strobes
//   frameerr     : one-clock pulse when a frame aborts
interface spi_slave_sync_if;
  logic       sclk;
  logic       ss;
  logic       mosi;
  logic [7:0] rddata;
  logic       miso;
  logic       spioe;
  logic [3:0] addr;
  logic [7:0] wrtdata;
  logic       we;
  logic       rdt;
  logic       frameerr;

  modport slave (
    input  sclk, ss, mosi, rddata,
    output miso, spioe, addr, wrtdata, we, rdt, frameerr
  );
  modport master (
    output sclk, ss, mosi, rddata,
    input  miso, spioe, addr, wrtdata, we, rdt, frameerr
  );
endinterface

// File: rtl/spi_slave_sync_syncedge.sv
// syncedge: SYNCSTAGES-flop synchronizer followed by one edge-detect flop.
//   clk, rstn : system clock, async active-low reset
//   i_pin     : asynchronous input pin
//   o_level   : synchronized level
//   o_rise    : one-clock pulse on synchronized 0->1
//   o_fall    : one-clock pulse on synchronized 1->0
module syncedge #(
  parameter int   SYNCSTAGES = 2,
  parameter logic RSTVAL     = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNCSTAGES-1:0] r_sync;
  logic                  r_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= {SYNCSTAGES{RSTVAL}};
      r_prev <= RSTVAL;
    end else begin
      r_sync <= {r_sync[SYNCSTAGES-2:0], i_pin};
      r_prev <= r_sync[SYNCSTAGES-1];
    end
  end

  assign o_level = r_sync[SYNCSTAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;
endmodule

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: oversampled SPI mode-0 slave, 16-bit frames
// (command byte then data byte, MSB first).
//   clk, rstn : system clock, async active-low reset
//   bus       : spi_slave_sync_if.slave (pins + register-file side)
// Command bit7=1 writes the data byte to addr; bit7=0 reads rddata out
// on MISO during the data byte.
module spi_slave_sync
  import spi_slave_pkg::*;
#(
  parameter int SYNCSTAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  spi_slave_sync_if.slave   bus
);
  logic w_sclk_rise, w_sclk_fall, w_sclk_level;
  logic w_ss_rise, w_ss_fall, w_ss_level;
  logic w_mosi, w_mosi_unused_rise, w_mosi_unused_fall;

  syncedge #(.SYNCSTAGES(SYNCSTAGES), .RSTVAL(1'b0)) u_sclk (
    .clk(clk), .rstn(rstn), .i_pin(bus.sclk),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  syncedge #(.SYNCSTAGES(SYNCSTAGES), .RSTVAL(1'b1)) u_ss (
    .clk(clk), .rstn(rstn), .i_pin(bus.ss),
    .o_level(w_ss_level), .o_rise(w_ss_rise), .o_fall(w_ss_fall));
  syncedge #(.SYNCSTAGES(SYNCSTAGES), .RSTVAL(1'b0)) u_mosi (
    .clk(clk), .rstn(rstn), .i_pin(bus.mosi),
    .o_level(w_mosi), .o_rise(w_mosi_unused_rise), .o_fall(w_mosi_unused_fall));

  state_t          r_state, w_next;
  logic [3:0]      r_cnt;
  logic [7:0]      r_rx, r_tx;
  logic            r_wrfrm, r_rdfrm, r_rd_pend, r_armed;
  logic [SYNCSTAGES:0] r_warm;
  logic            r_miso, r_spioe, r_we, r_rdt, r_frameerr;
  logic [3:0]      r_addr;
  logic [7:0]      r_wrtdata;
  logic            w_start, w_inframe, w_shift, w_abort, w_cmd_end, w_frame_end;

  // Frame start needs a genuine high-then-low on ss: r_armed only sets once
  // the synchronizer has flushed its reset value and shows ss high.
  assign w_start     = (r_state == IDLE) & w_ss_fall & r_armed;
  assign w_inframe   = (r_state == CMD) | (r_state == DATA);
  assign w_abort     = w_inframe & w_ss_rise;
  assign w_shift     = w_inframe & w_sclk_rise & ~w_ss_rise;
  assign w_cmd_end   = (r_state == CMD)  & w_shift & (r_cnt == 4'(CMDBITS-1));
  assign w_frame_end = (r_state == DATA) & w_shift & (r_cnt == 4'(FRAMEBITS-1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_start) w_next = CMD;
      CMD:  if (w_abort) w_next = IDLE; else if (w_cmd_end) w_next = DATA;
      DATA: if (w_abort) w_next = IDLE; else if (w_frame_end) w_next = DONE;
      DONE: if (w_ss_rise) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0; r_rx <= '0; r_tx <= '0;
      r_wrfrm <= 1'b0; r_rdfrm <= 1'b0; r_rd_pend <= 1'b0;
      r_armed <= 1'b0; r_warm <= '0;
      r_miso <= 1'b0; r_spioe <= 1'b0; r_we <= 1'b0; r_rdt <= 1'b0;
      r_frameerr <= 1'b0; r_addr <= '0; r_wrtdata <= '0;
    end else begin
      r_we       <= 1'b0;
      r_rdt      <= 1'b0;
      r_frameerr <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_spioe    <= ~w_ss_level;
      r_warm     <= {r_warm[SYNCSTAGES-1:0], 1'b1};
      if (r_warm[SYNCSTAGES] && w_ss_level) r_armed <= 1'b1;

      if (w_start) begin
        r_cnt   <= '0;
        r_wrfrm <= 1'b0;
        r_rdfrm <= 1'b0;
      end
      // Count wraps 15->0 exactly on the DATA->DONE transition.
      if (w_shift) begin
        r_rx  <= {r_rx[6:0], w_mosi};
        r_cnt <= r_cnt + 4'd1;
      end
      // r_rx holds command bits 7..1 here; the last bit comes straight off mosi.
      if (w_cmd_end) begin
        r_addr    <= {r_rx[2:0], w_mosi};
        r_wrfrm   <= r_rx[WRBIT-1];
        r_rdfrm   <= ~r_rx[WRBIT-1];
        r_rd_pend <= ~r_rx[WRBIT-1];
      end
      // rddata is valid one cycle after addr updates.
      if (r_rd_pend) begin
        r_rdt <= 1'b1;
        r_tx  <= bus.rddata;
      end
      if (w_frame_end && r_wrfrm) begin
        r_we      <= 1'b1;
        r_wrtdata <= {r_rx[6:0], w_mosi};
      end
      if (w_abort) r_frameerr <= 1'b1;

      if (r_state == DATA) begin
        if (w_sclk_fall && !w_ss_rise && r_rdfrm) begin
          r_miso <= r_tx[7];
          r_tx   <= {r_tx[6:0], 1'b0};
        end
      end else begin
        r_miso <= 1'b0;
      end
    end
  end

  assign bus.miso     = r_miso;
  assign bus.spioe    = r_spioe;
  assign bus.addr     = r_addr;
  assign bus.wrtdata  = r_wrtdata;
  assign bus.we       = r_we;
  assign bus.rdt      = r_rdt;
  assign bus.frameerr = r_frameerr;
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed SPI frames against spi_slave_sync with a
// scoreboard of expected strobe events checked by an independent monitor.
module tb_spi_slave_sync;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spi_slave_sync_if bus();
  spi_slave_sync #(.SYNCSTAGES(2)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  // Register-file read mux model.
  assign bus.rddata = (bus.addr == 4'h0) ? 8'hC3 :
                      (bus.addr == 4'h9) ? 8'h3C : 8'h00;

  typedef struct {
    int         kind;   // 0 = we, 1 = rdt, 2 = frameerr
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t q[$];
  int  nvec = 0;
  int  nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [3:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  // Monitor: every strobe must match the next expected event.
  initial begin
    int  kind;
    ev_t e;
    forever begin
      @(negedge clk);
      if (bus.we && bus.rdt) chk("we_rdt_exclusive", 32'(bus.we & bus.rdt), 32'd0);
      if (bus.we || bus.rdt || bus.frameerr) begin
        kind = bus.we ? 0 : (bus.rdt ? 1 : 2);
        if (q.size() == 0) begin
          chk("unexpected_event_kind", 32'(kind), 32'd99);
        end else begin
          e = q.pop_front();
          chk("event_kind", 32'(kind), 32'(e.kind));
          chk("event_addr", 32'(bus.addr), 32'(e.addr));
          if (kind == 0) chk("wrtdata", 32'(bus.wrtdata), 32'(e.data));
        end
      end
    end
  end

  // Drive one frame: sclk half period = 5 clk. abort_at>0 stops after that
  // many pulses; keep_ss leaves ss low (for reset abort).
  task automatic frame(input logic [15:0] bits, input int npulse, input int abort_at,
                       input bit keep_ss, input int gap, output logic [7:0] rxb);
    rxb = 8'h00;
    @(negedge clk);
    bus.ss = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < npulse; i++) begin
      if (abort_at != 0 && i == abort_at) break;
      bus.mosi = (i < 16) ? bits[15-i] : 1'b0;
      repeat (5) @(negedge clk);
      bus.sclk = 1'b1;
      if (i >= 8 && i < 16) rxb[15-i] = bus.miso;
      if (i == 4) chk("spioe_in_frame", 32'(bus.spioe), 32'd1);
      repeat (5) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
    if (!keep_ss) begin
      bus.ss = 1'b1;
      repeat (3) @(negedge clk);
      chk("spioe_between", 32'(bus.spioe), 32'd0);
      repeat (gap - 3) @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] rb;
    bus.sclk = 1'b0; bus.ss = 1'b1; bus.mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso",     32'(bus.miso),     32'd0);
    chk("rst_spioe",    32'(bus.spioe),    32'd0);
    chk("rst_addr",     32'(bus.addr),     32'd0);
    chk("rst_wrtdata",  32'(bus.wrtdata),  32'd0);
    chk("rst_strobes",  32'({bus.we, bus.rdt, bus.frameerr}), 32'd0);
    rstn = 1'b1;
    repeat (6) @(negedge clk);

    // Plain write.
    push(0, 4'h2, 8'h5A);
    frame(16'h825A, 16, 0, 1'b0, 8, rb);
    chk("miso_write_idle", 32'(rb), 32'h00);

    // Read, rddata(0) = C3.
    push(1, 4'h0, 8'h00);
    frame(16'h00FF, 16, 0, 1'b0, 8, rb);
    chk("miso_read_0", 32'(rb), 32'hC3);

    // Abort after 12 bits of a write.
    push(2, 4'hF, 8'h00);
    frame(16'h8F33, 16, 12, 1'b0, 8, rb);
    chk("wrtdata_after_abort", 32'(bus.wrtdata), 32'h5A);
    push(0, 4'h4, 8'h11);
    frame(16'h8411, 16, 0, 1'b0, 8, rb);

    // 20 sclk pulses: extras ignored.
    push(0, 4'h6, 8'h77);
    frame(16'h8677, 20, 0, 1'b0, 8, rb);

    // Reset during the data byte of a write.
    frame(16'h8199, 16, 12, 1'b1, 8, rb);
    rstn = 1'b0;
    #1;
    chk("midrst_addr",    32'(bus.addr),    32'd0);
    chk("midrst_wrtdata", 32'(bus.wrtdata), 32'd0);
    chk("midrst_out",     32'({bus.miso, bus.spioe, bus.we, bus.rdt, bus.frameerr}), 32'd0);
    bus.ss = 1'b1; bus.sclk = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    push(0, 4'h1, 8'h22);
    frame(16'h8122, 16, 0, 1'b0, 8, rb);

    // Back-to-back read then write, 4 clk of ss high between.
    push(1, 4'h9, 8'h00);
    frame(16'h0900, 16, 0, 1'b0, 4, rb);
    chk("miso_read_9", 32'(rb), 32'h3C);
    push(0, 4'hA, 8'h10);
    frame(16'h8A10, 16, 0, 1'b0, 8, rb);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
